// File: rtl/fullsend_mem_pkg.sv
// Shared types and constants for the memory-port arbiter.
package fullsend_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY_IF = 2'd1,
    ARB_BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic MEM_RD = 1'b0;
  localparam logic MEM_WR = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF requester, DM requester and memory-side signals of the arbiter.
// slave: the arbiter's view. master: the pipeline/memory environment's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  // Instruction fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;

  // Data access side
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_valid;
  logic              dm_stall;

  // Memory side
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_input;
  logic              mem_enable;
  logic              mem_r_w;
  logic [DATA_W-1:0] mem_output;
  logic              mem_ready;

  logic              timeout_err;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_stall,
    output mem_address, mem_input, mem_enable, mem_r_w,
    input  mem_output, mem_ready,
    output timeout_err
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_stall,
    input  mem_address, mem_input, mem_enable, mem_r_w,
    output mem_output, mem_ready,
    input  timeout_err
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch (IF) and data access (DM).
// DM wins by default; after MAX_DATA_STREAK back-to-back DM grants with IF waiting, IF is forced.
// No new grant is made while a completion pulse is out, so a requester that advances on its
// valid pulse never has its stale request re-granted.
module mem_port_arbiter
  import fullsend_mem_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  arb_state_t        state;
  logic [SW-1:0]     streak;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic              done;
  logic [DATA_W-1:0] resp_data;

  // Stalls follow the request until its completion pulse.
  assign bus.if_stall = bus.if_req & ~bus.if_valid;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_valid;

  // Completion/abort decode for the current BUSY cycle; ready wins over an expiring timeout.
  always_comb begin
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);
    done      = bus.mem_ready | tmo_hit;
    resp_data = '0;
    if (bus.mem_ready && (bus.mem_r_w == MEM_RD)) begin
      resp_data = bus.mem_output;
    end
  end

  // Arbiter FSM with streak/timeout counters and registered memory-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ARB_IDLE;
      streak          <= '0;
      tmo_cnt         <= '0;
      bus.mem_address <= {ADDR_W{1'b0}};
      bus.mem_input   <= '0;
      bus.mem_enable  <= 1'b0;
      bus.mem_r_w     <= MEM_RD;
      bus.if_rdata    <= '0;
      bus.if_valid    <= 1'b0;
      bus.dm_rdata    <= '0;
      bus.dm_valid    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.if_valid <= 1'b0;
      bus.dm_valid <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          tmo_cnt <= '0;
          if (!bus.if_req) begin
            streak <= '0;
          end
          if (!bus.if_valid && !bus.dm_valid) begin
            if (bus.dm_req && (!bus.if_req || (streak < STREAK_MAX))) begin
              state           <= ARB_BUSY_DM;
              bus.mem_address <= bus.dm_addr;
              bus.mem_input   <= bus.dm_wdata;
              bus.mem_r_w     <= bus.dm_we;
              bus.mem_enable  <= 1'b1;
              if (bus.if_req && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
              end
            end else if (bus.if_req) begin
              state           <= ARB_BUSY_IF;
              bus.mem_address <= bus.if_addr;
              bus.mem_input   <= '0;
              bus.mem_r_w     <= MEM_RD;
              bus.mem_enable  <= 1'b1;
              streak          <= '0;
            end
          end
        end
        ARB_BUSY_IF, ARB_BUSY_DM: begin
          if (done) begin
            state          <= ARB_IDLE;
            tmo_cnt        <= '0;
            bus.mem_enable <= 1'b0;
            if (!bus.mem_ready) begin
              bus.timeout_err <= 1'b1;
            end
            if (state == ARB_BUSY_IF) begin
              bus.if_valid <= 1'b1;
              bus.if_rdata <= resp_data;
            end else begin
              bus.dm_valid <= 1'b1;
              bus.dm_rdata <= resp_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MAX_DATA_STREAK(4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model knobs
  int          mem_lat     = 0;
  logic [31:0] mem_rd      = '0;
  bit          ready_const = 1'b0;
  bit          mem_hold    = 1'b0;

  // Behavioural memory: ready after mem_lat enabled cycles, or held high, or never.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready  = 1'b0;
    bus.mem_output = '0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_const) begin
        bus.mem_ready  = 1'b1;
        bus.mem_output = mem_rd;
      end else if (bus.mem_enable) begin
        if (!mem_hold && cnt == mem_lat) begin
          bus.mem_ready  = 1'b1;
          bus.mem_output = mem_rd;
        end else begin
          bus.mem_ready = 1'b0;
        end
        cnt++;
      end else begin
        cnt = 0;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Grant log: address presented on each rising edge of mem_enable.
  logic [31:0] grant_q[$];
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_enable && !prev_en) grant_q.push_back(bus.mem_address);
      prev_en = bus.mem_enable;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for a valid pulse; cyc = -1 if it never arrives.
  task automatic wait_valid(input bit is_dm, output int cyc, output int en_cyc,
                            output logic [31:0] addr, output logic rw,
                            output logic [31:0] wd, output bit own_stall, output bit oth_stall);
    cyc = -1; en_cyc = 0; addr = '0; rw = 1'b0; wd = '0; own_stall = 1'b1; oth_stall = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (is_dm ? bus.dm_valid : bus.if_valid) begin
        cyc = i;
        break;
      end
      if (bus.mem_enable) begin
        en_cyc++;
        addr = bus.mem_address;
        rw   = bus.mem_r_w;
        wd   = bus.mem_input;
      end
      if (!(is_dm ? bus.dm_stall : bus.if_stall)) own_stall = 1'b0;
      if (!(is_dm ? bus.if_stall : bus.dm_stall)) oth_stall = 1'b0;
    end
  endtask

  int          cyc, en_cyc, prev_t, first_t, n_v;
  logic [31:0] w_addr, w_wd, exp_addr;
  logic        w_rw;
  bit          own_st, oth_st, addr_ok, rdata_ok;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_mem_enable", bus.mem_enable, 0);
    check_eq("rst_mem_address", bus.mem_address, 0);
    check_eq("rst_valids", {bus.if_valid, bus.dm_valid}, 0);
    check_eq("rst_timeout_err", bus.timeout_err, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_eq("idle_no_enable", bus.mem_enable, 0);

    // 1. Lone load with 3 wait cycles
    mem_lat = 3; mem_rd = 32'hDEAD_BEEF;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h100;
    #1;
    check_eq("t1_stall_comb", bus.dm_stall, 1);
    wait_valid(1'b1, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("t1_latency", cyc, 5);
    check_eq("t1_en_cycles", en_cyc, 4);
    check_eq("t1_addr", w_addr, 32'h100);
    check_eq("t1_rw", w_rw, 0);
    check_eq("t1_stall_held", own_st, 1);
    check_eq("t1_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
    check_eq("t1_stall_done", bus.dm_stall, 0);
    bus.dm_req = 1'b0;
    tick();
    check_eq("t1_one_pulse", bus.dm_valid, 0);
    check_eq("t1_enable_off", bus.mem_enable, 0);

    // 2. Simultaneous IF read and DM store: DM first
    mem_lat = 1; mem_rd = 32'h5555_AAAA;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h200; bus.dm_wdata = 32'h1234;
    wait_valid(1'b1, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("t2_dm_latency", cyc, 3);
    check_eq("t2_dm_addr", w_addr, 32'h200);
    check_eq("t2_dm_rw", w_rw, 1);
    check_eq("t2_dm_wdata", w_wd, 32'h1234);
    check_eq("t2_if_stall_during_dm", oth_st, 1);
    check_eq("t2_store_rdata", bus.dm_rdata, 0);
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    wait_valid(1'b0, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("t2_if_latency", cyc, 4);
    check_eq("t2_if_addr", w_addr, 32'h0);
    check_eq("t2_if_rw", w_rw, 0);
    check_eq("t2_if_input", w_wd, 0);
    check_eq("t2_if_stall", own_st, 1);
    check_eq("t2_if_rdata", bus.if_rdata, 32'h5555_AAAA);
    bus.if_req = 1'b0;
    tick();

    // 3. Starvation guard: 4 DM, then IF, then DM again
    mem_lat = 0; mem_rd = 32'h0;
    grant_q.delete();
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h300;
    repeat (17) tick();
    check_eq("t3_grant_count", grant_q.size() >= 6, 1);
    if (grant_q.size() >= 6) begin
      for (int g = 0; g < 6; g++) begin
        check_eq($sformatf("t3_grant%0d", g), grant_q[g], (g == 4) ? 32'h40 : 32'h300);
      end
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (3) tick();

    // 6. Zero-wait memory, IF streaming, if_addr perturbed mid-access
    ready_const = 1'b1; mem_rd = 32'hCAFE_F00D;
    exp_addr = 32'h1000; bus.if_addr = exp_addr; bus.if_req = 1'b1;
    prev_t = 0; first_t = 0; n_v = 0; addr_ok = 1'b1; rdata_ok = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (bus.mem_enable && bus.mem_address !== exp_addr) addr_ok = 1'b0;
      if (bus.if_valid) begin
        n_v++;
        if (bus.if_rdata !== 32'hCAFE_F00D) rdata_ok = 1'b0;
        if (prev_t != 0) check_eq("t6_period", t - prev_t, 3);
        else first_t = t;
        prev_t = t;
        exp_addr = exp_addr + 32'd4;
      end
      bus.if_addr = bus.mem_enable ? 32'hBAD0_0000 : exp_addr;
    end
    check_eq("t6_first_valid", first_t, 2);
    check_eq("t6_pulses", n_v, 4);
    check_eq("t6_addr_latched", addr_ok, 1);
    check_eq("t6_rdata", rdata_ok, 1);
    bus.if_req = 1'b0;
    tick();
    ready_const = 1'b0;
    tick();

    // 4. Timeout: memory never answers
    mem_hold = 1'b1; mem_rd = 32'h77;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
    wait_valid(1'b1, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("t4_abort_cycle", cyc, 9);
    check_eq("t4_busy_cycles", en_cyc, 8);
    check_eq("t4_rdata_zero", bus.dm_rdata, 0);
    check_eq("t4_enable_dropped", bus.mem_enable, 0);
    check_eq("t4_err_set", bus.timeout_err, 1);
    bus.dm_req = 1'b0; mem_hold = 1'b0; mem_lat = 0; mem_rd = 32'h1111_2222;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    wait_valid(1'b0, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("t4_next_if_latency", cyc, 3);
    check_eq("t4_next_if_rdata", bus.if_rdata, 32'h1111_2222);
    check_eq("t4_err_sticky", bus.timeout_err, 1);
    bus.if_req = 1'b0;
    tick();

    // 5. Reset while BUSY_IF
    mem_hold = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h800;
    tick();
    check_eq("t5_busy_enable", bus.mem_enable, 1);
    check_eq("t5_busy_addr", bus.mem_address, 32'h800);
    #1 reset = 1'b0;
    #1;
    check_eq("t5_async_enable", bus.mem_enable, 0);
    check_eq("t5_async_addr", bus.mem_address, 0);
    check_eq("t5_async_err", bus.timeout_err, 0);
    check_eq("t5_async_valid", bus.if_valid, 0);
    bus.if_req = 1'b0;
    @(negedge clk);
    reset = 1'b1; mem_hold = 1'b0;
    tick();
    tick();
    check_eq("t5_idle_enable", bus.mem_enable, 0);
    check_eq("t5_no_ghost_valid", bus.if_valid, 0);

    // Boundary: ready arrives on the final timeout cycle -> normal completion
    mem_lat = 7; mem_rd = 32'hABCD_0123;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    wait_valid(1'b1, cyc, en_cyc, w_addr, w_rw, w_wd, own_st, oth_st);
    check_eq("tb_edge_latency", cyc, 9);
    check_eq("tb_edge_rdata", bus.dm_rdata, 32'hABCD_0123);
    check_eq("tb_edge_no_err", bus.timeout_err, 0);
    bus.dm_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
